// File: rtl/wb_bram_burst.sv
// Wishbone B4 registered-feedback RAM slave with classic, constant and incrementing
// (linear / wrap-4/8/16) bursts at one beat per clock, and bus error past MEM_WORDS.
module wb_bram_burst #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_WORDS    = 2 ** (ADDR_WIDTH - $clog2(SELECT_WIDTH))
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int LSB   = $clog2(SELECT_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - LSB;
    localparam logic [IDX_W:0] C_LIMIT = (IDX_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_BURST  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ack;
    logic                  r_err;
    logic [IDX_W-1:0]      r_burst_idx;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  w_ack_nxt;
    logic                  w_err_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_load;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_req_idx;
    logic                  w_cont;
    logic                  w_beat;
    logic [IDX_W-1:0]      w_wrap_mask;
    logic [IDX_W-1:0]      w_inc;
    logic [IDX_W:0]        w_nidx;

    assign w_req_idx = adr_i[ADDR_WIDTH-1:LSB];
    assign w_cont    = (cti_i == 3'b001) || (cti_i == 3'b010);
    assign w_beat    = r_ack & cyc_i & stb_i;
    assign w_inc     = r_burst_idx + IDX_W'(1);

    // Next burst index; the extra MSB catches linear overflow past the address space
    always_comb begin
        case (bte_i)
            2'b01:   w_wrap_mask = IDX_W'(3);
            2'b10:   w_wrap_mask = IDX_W'(7);
            2'b11:   w_wrap_mask = IDX_W'(15);
            default: w_wrap_mask = '0;
        endcase
        if (cti_i == 3'b001) begin
            w_nidx = {1'b0, r_burst_idx};
        end else if (bte_i == 2'b00) begin
            w_nidx = {1'b0, r_burst_idx} + (IDX_W + 1)'(1);
        end else begin
            w_nidx = {1'b0, (r_burst_idx & ~w_wrap_mask) | (w_inc & w_wrap_mask)};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next datapath values
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_idx_nxt   = r_burst_idx;
        w_load      = 1'b0;
        w_rd_idx    = r_burst_idx;
        case (r_state)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    if ({1'b0, w_req_idx} >= C_LIMIT) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = w_req_idx;
                        w_rd_idx    = w_req_idx;
                        w_load      = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = w_cont ? S_BURST : S_SINGLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SINGLE: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (!cyc_i) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (w_beat && !w_cont) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (w_beat && (w_nidx >= C_LIMIT)) begin
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_beat) begin
                    w_idx_nxt = w_nidx[IDX_W-1:0];
                    w_rd_idx  = w_nidx[IDX_W-1:0];
                    w_load    = 1'b1;
                end else begin
                    w_state_nxt = S_BURST;
                end
            end
            S_DONE: begin
                w_ack_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake, burst index and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_burst_idx <= '0;
            r_dat       <= '0;
        end else begin
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_burst_idx <= w_idx_nxt;
            if (w_load) begin
                r_dat <= r_mem[w_rd_idx];
            end
        end
    end

    // Memory array is never reset; a write commits only on a completed beat
    always_ff @(posedge clk) begin
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (w_beat && we_i && sel_i[i]) begin
                r_mem[r_burst_idx][i*8 +: 8] <= dat_i[i*8 +: 8];
            end
        end
    end

    // Bus outputs are qualified by the live strobe
    always_comb begin
        ack_o = w_beat;
        err_o = r_err & cyc_i & stb_i;
        dat_o = r_dat;
    end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Scoreboarded random and directed bench for wb_bram_burst (MEM_WORDS=768).
module tb_wb_bram_burst;
    localparam int MW = 768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic [2:0]  cti_i = '0;
    logic [1:0]  bte_i = '0;
    logic        ack_o;
    logic        err_o;

    wb_bram_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i),
        .bte_i(bte_i), .ack_o(ack_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [1024];
    logic [3:0]  known [1024];
    logic [31:0] wdata [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference word index for beat k of a burst
    function automatic int model_idx(input int start, input logic [2:0] cont,
                                     input logic [1:0] bte, input int k);
        int n;
        if (cont == 3'b001) return start;
        if (bte == 2'b00) return start + k;
        n = 4 << (bte - 2'd1);
        return (start - start % n) + ((start % n + k) % n);
    endfunction

    function automatic logic [31:0] known_mask(input int idx);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = known[idx][i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Monitor: every ack/err pops one expectation
    always @(negedge clk) begin
        if (rst_n && (ack_o || err_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {30'd0, err_o, ack_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_kind", {30'd0, err_o, ack_o}, {30'd0, mon_e.is_err, !mon_e.is_err});
                if (!mon_e.is_err && mon_e.mask != 32'd0)
                    check("rdata", dat_o & mon_e.mask, mon_e.data & mon_e.mask);
            end
        end
    end

    task automatic xfer(input int start, input bit we, input logic [2:0] cont,
                        input logic [1:0] bte, input int nb, input logic [3:0] sel,
                        input int wait_beat, input int wait_len, input int rst_beat);
        int   idx;
        int   n;
        bit   last;
        exp_t e;
        logic [31:0] hold;
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; bte_i = bte;
        adr_i = 12'(start * 4);
        for (int k = 0; k < nb; k++) begin
            idx  = model_idx(start, cont, bte, k);
            last = (k == nb - 1);
            cti_i = (nb == 1) ? 3'b000 : (last ? 3'b111 : cont);
            dat_i = wdata[k];
            e.is_err = (idx >= MW);
            e.data = e.is_err ? 32'd0 : mem_m[idx];
            e.mask = (e.is_err || we) ? 32'd0 : known_mask(idx);
            exp_q.push_back(e);
            n = 0;
            do begin @(negedge clk); n++; end while (!(ack_o || err_o) && n < 8);
            if (!(ack_o || err_o)) begin
                check("timeout", {31'd0, ack_o | err_o}, 32'd1);
                void'(exp_q.pop_back());
                cyc_i = 1'b0; stb_i = 1'b0;
                return;
            end
            check("lat", 32'(n), (k == 0) ? 32'd2 : 32'd1);
            if (k == rst_beat) begin
                #2 rst_n = 1'b0;
                #1 check("rst_ack", {31'd0, ack_o}, 32'd0);
                check("rst_dat", dat_o, 32'd0);
                cyc_i = 1'b0; stb_i = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            if (err_o) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("err_clear", {30'd0, err_o, ack_o}, 32'd0);
                cyc_i = 1'b0; stb_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (we) begin
                for (int i = 0; i < 4; i++) if (sel[i]) begin
                    mem_m[idx][i*8 +: 8] = wdata[k][i*8 +: 8];
                    known[idx][i] = 1'b1;
                end
            end
            if (k == wait_beat && !last) begin
                stb_i = 1'b0;
                hold = dat_o;
                for (int w = 0; w < wait_len; w++) begin
                    @(negedge clk);
                    check("wait_ack", {31'd0, ack_o}, 32'd0);
                    check("wait_dat", dat_o, hold);
                    @(posedge clk); #1;
                end
                stb_i = 1'b1;
            end
        end
        @(negedge clk);
        check("tail_idle", {30'd0, err_o, ack_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic wr1(input int w, input logic [31:0] d, input logic [3:0] sel);
        wdata[0] = d;
        xfer(w, 1'b1, 3'b000, 2'b00, 1, sel, -1, 0, -1);
    endtask

    task automatic rd1(input int w);
        xfer(w, 1'b0, 3'b000, 2'b00, 1, 4'hF, -1, 0, -1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int nb;
        bit we;
        for (int i = 0; i < 1024; i++) begin mem_m[i] = '0; known[i] = '0; end
        for (int i = 0; i < 16; i++) wdata[i] = '0;

        // reset state with a request pending
        #1 cyc_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        check("reset_outs", {30'd0, err_o, ack_o}, 32'd0);
        check("reset_dat", dat_o, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        wr1(4, 32'hDEADBEEF, 4'hF);
        rd1(4);
        check("classic_rd", dat_o, 32'hDEADBEEF);

        wr1(8, 32'h11223344, 4'hF);
        wr1(8, 32'hAABBCCDD, 4'b0101);
        rd1(8);
        check("byte_merge", dat_o, 32'h11BB33DD);

        for (int i = 0; i < 4; i++) wr1(16 + i, 32'hA000_0010 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) wr1(28 + i, 32'hB000_001C + 32'(i), 4'hF);
        xfer(16, 1'b0, 3'b010, 2'b00, 4, 4'hF, -1, 0, -1);
        check("lin_last", dat_o, 32'hA000_0013);
        xfer(30, 1'b0, 3'b010, 2'b01, 4, 4'hF, 1, 2, -1);
        check("wrap4_last", dat_o, 32'hB000_001D);

        wr1(768, 32'h12345678, 4'hF);
        wr1(766, 32'hC000_0766, 4'hF);
        wr1(767, 32'hC000_0767, 4'hF);
        xfer(766, 1'b0, 3'b010, 2'b00, 4, 4'hF, -1, 0, -1);

        for (int i = 0; i < 4; i++) wr1(48 + i, 32'h5A5A_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) wdata[i] = 32'hF00D_0000 + 32'(i);
        xfer(48, 1'b1, 3'b010, 2'b00, 4, 4'hF, -1, 0, 2);
        rd1(48); check("rst_beat1", dat_o, 32'hF00D_0000);
        rd1(49); check("rst_beat2", dat_o, 32'hF00D_0001);
        rd1(50); check("rst_beat3", dat_o, 32'h5A5A_0002);
        rd1(51); check("rst_beat4", dat_o, 32'h5A5A_0003);

        for (int t = 0; t < 80; t++) begin
            s  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(740, 775)) : int'($urandom_range(0, 40));
            nb = $urandom_range(1, 6);
            we = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 16; i++) wdata[i] = $urandom;
            xfer(s, we, ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010, 2'($urandom_range(0, 3)),
                 nb, we ? 4'($urandom_range(1, 15)) : 4'hF,
                 $urandom_range(0, 6), $urandom_range(1, 2), -1);
        end

        repeat (3) @(negedge clk);
        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
